// File: rtl/ps2_pkg.sv
// PS/2 shared definitions: host transmitter states, common command
// bytes and a microsecond-to-clock-cycle helper.
package ps2_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_ACK,
        ST_WAIT_IDLE,
        ST_DONE,
        ST_FAIL
    } ps2_tx_state_e;

    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
    localparam logic [7:0] PS2_RSP_ACK      = 8'hFA;

    function automatic int us_to_cycles(
        input int clk_hz,
        input int us
    );
        return (clk_hz / 1_000_000) * us;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser for the PS/2 clock and data pins plus a
// falling-edge strobe on the synchronised clock line.
module ps2_line_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic clk_line_i,
    input  logic data_line_i,
    output logic clk_s_o,
    output logic data_s_o,
    output logic clk_fall_o
);

    logic [1:0] clk_sync_q;
    logic [1:0] data_sync_q;
    logic       clk_prev_q;

    // Idle bus level is high, so reset to 1 to avoid a fake edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_prev_q  <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], clk_line_i};
            data_sync_q <= {data_sync_q[0], data_line_i};
            clk_prev_q  <= clk_sync_q[1];
        end
    end

    assign clk_s_o    = clk_sync_q[1];
    assign data_s_o   = data_sync_q[1];
    assign clk_fall_o = clk_prev_q & ~clk_sync_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter (open-drain clk/data enables).
// Optional retry on failed frames: define PS2_TX_RETRY_EN.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int CLK_HZ     = 28_000_000,
    parameter int INHIBIT_US = 120,
    parameter int TIMEOUT_US = 15000
`ifdef PS2_TX_RETRY_EN
    ,
    parameter int MAX_RETRY  = 2
`endif
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_err,
    output logic       busy,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int INHIBIT_CYC = us_to_cycles(CLK_HZ, INHIBIT_US);
    localparam int TIMEOUT_CYC = us_to_cycles(CLK_HZ, TIMEOUT_US);
    localparam int MAX_CYC =
        (TIMEOUT_CYC > INHIBIT_CYC) ? TIMEOUT_CYC : INHIBIT_CYC;
    localparam int CW = $clog2(MAX_CYC + 1);

    ps2_tx_state_e state_q, state_d;
    ps2_tx_state_e fail_state;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    byte_q, byte_d;
    logic          drv_q, drv_d;

    logic clk_s, data_s, clk_fall;
    logic cnt_zero, in_frame, fail, parity;

    ps2_line_sync u_sync (
        .clk        (clk),
        .reset_n    (reset_n),
        .clk_line_i (ps2_clk_in),
        .data_line_i(ps2_data_in),
        .clk_s_o    (clk_s),
        .data_s_o   (data_s),
        .clk_fall_o (clk_fall)
    );

    assign cnt_zero = (cnt_q == '0);
    assign parity   = ~^byte_q;
    assign in_frame = state_q inside {ST_START, ST_DATA, ST_PARITY,
                                      ST_STOP, ST_ACK, ST_WAIT_IDLE};
    // NACK = data still high on the 11th falling edge.
    assign fail = in_frame &&
                  (cnt_zero ||
                   (state_q == ST_ACK && clk_fall && data_s));

`ifdef PS2_TX_RETRY_EN
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    logic [RW-1:0] retry_q, retry_d;

    assign fail_state =
        (retry_q < RW'(MAX_RETRY)) ? ST_INHIBIT : ST_FAIL;

    always_comb begin
        retry_d = retry_q;
        if (state_q == ST_IDLE) begin
            retry_d = '0;
        end else if (fail && fail_state == ST_INHIBIT) begin
            retry_d = retry_q + RW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) retry_q <= '0;
        else          retry_q <= retry_d;
    end
`else
    assign fail_state = ST_FAIL;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:      if (tx_valid) state_d = ST_INHIBIT;
            ST_INHIBIT:   if (cnt_zero) state_d = ST_START;
            ST_START:     if (clk_fall) state_d = ST_DATA;
            ST_DATA:      if (clk_fall && idx_q == 3'd7)
                              state_d = ST_PARITY;
            ST_PARITY:    if (clk_fall) state_d = ST_STOP;
            ST_STOP:      if (clk_fall) state_d = ST_ACK;
            ST_ACK:       if (clk_fall) state_d = ST_WAIT_IDLE;
            ST_WAIT_IDLE: if (clk_s && data_s) state_d = ST_DONE;
            default:      state_d = ST_IDLE;
        endcase
        if (fail) state_d = fail_state;
    end

    always_comb begin
        ps2_clk_oe  = 1'b0;
        ps2_data_oe = 1'b0;
        unique case (state_q)
            ST_INHIBIT: begin
                ps2_clk_oe  = 1'b1;
                ps2_data_oe = cnt_zero;
            end
            ST_START, ST_DATA, ST_PARITY, ST_STOP:
                ps2_data_oe = drv_q;
            default: ;
        endcase
        tx_ready = (state_q == ST_IDLE);
        busy     = (state_q != ST_IDLE);
        tx_done  = (state_q == ST_DONE);
        tx_err   = (state_q == ST_FAIL);
    end

    // One counter serves the inhibit time and the frame timeout.
    always_comb begin
        cnt_d  = cnt_q;
        idx_d  = idx_q;
        byte_d = byte_q;
        drv_d  = drv_q;
        if (state_q == ST_IDLE && tx_valid) begin
            byte_d = tx_data;
            cnt_d  = CW'(INHIBIT_CYC - 1);
        end else if (fail && fail_state == ST_INHIBIT) begin
            cnt_d = CW'(INHIBIT_CYC - 1);
        end else if (state_q == ST_INHIBIT && cnt_zero) begin
            cnt_d = CW'(TIMEOUT_CYC - 1);
            drv_d = 1'b1;
            idx_d = 3'd0;
        end else if (!cnt_zero) begin
            cnt_d = cnt_q - CW'(1);
        end
        if (clk_fall) begin
            unique case (state_q)
                ST_START, ST_DATA: begin
                    drv_d = ~byte_q[idx_q];
                    idx_d = idx_q + 3'd1;
                end
                ST_PARITY: drv_d = ~parity;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            idx_q  <= 3'd0;
            byte_q <= 8'h00;
            drv_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            byte_q <= byte_d;
            drv_q  <= drv_d;
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: device-side BFM on the open-drain lines,
// vector table, hand-written corner cases and random bytes.
module tb_ps2_host_tx;

    localparam int CLK_HZ     = 2_000_000;
    localparam int INHIBIT_US = 10;
    localparam int TIMEOUT_US = 400;
    localparam int INH = (CLK_HZ / 1_000_000) * INHIBIT_US;
    localparam int TO  = (CLK_HZ / 1_000_000) * TIMEOUT_US;
    localparam int HALF = 8;
`ifdef PS2_TX_RETRY_EN
    localparam int MAX_RETRY_TB = 2;
`else
    localparam int MAX_RETRY_TB = 0;
`endif
    localparam int ALLOWED = 1 + MAX_RETRY_TB;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, tx_done, tx_err, busy;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       dev_clk_low, dev_data_low;
    logic       ps2_clk_pin, ps2_data_pin;

    assign ps2_clk_pin  = !(ps2_clk_oe || dev_clk_low);
    assign ps2_data_pin = !(ps2_data_oe || dev_data_low);

    always #5 clk = ~clk;

    ps2_host_tx #(
        .CLK_HZ    (CLK_HZ),
        .INHIBIT_US(INHIBIT_US),
        .TIMEOUT_US(TIMEOUT_US)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_done    (tx_done),
        .tx_err     (tx_err),
        .busy       (busy),
        .ps2_clk_in (ps2_clk_pin),
        .ps2_data_in(ps2_data_pin),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int hi_w     = 0;
    int last_inh_w = 0;
    bit prev_clk_oe = 0;
    bit prev_pulse  = 0;
    bit hold_valid  = 0;

    task automatic check(input string nm, input longint act,
                         input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset_n) begin
            prev_pulse  = 0;
            prev_clk_oe = 0;
            hi_w        = 0;
        end else begin
            if (tx_done) done_cnt++;
            if (tx_err)  err_cnt++;
            if (tx_done || tx_err)
                check("done_err_exclusive", tx_done && tx_err, 0);
            if (prev_pulse) check("ready_after_pulse", tx_ready, 1);
            prev_pulse = tx_done || tx_err;
            if (ps2_clk_oe) hi_w++;
            else if (prev_clk_oe) begin
                last_inh_w = hi_w;
                hi_w = 0;
            end
            prev_clk_oe = ps2_clk_oe;
        end
    end

    function automatic bit odd_par(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) if (b[i]) ones++;
        return (ones % 2 == 0);
    endfunction

    task automatic wait_start(output bit seen);
        seen = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!busy) return;
            if (ps2_clk_pin && !ps2_data_pin) begin
                seen = 1;
                return;
            end
        end
    endtask

    // Device side: 11 clocks, read on rising edge, ACK after the 10th.
    task automatic dev_frame(input bit ack, output logic [9:0] bits);
        bits = '0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < 11; i++) begin
            dev_clk_low = 1;
            repeat (HALF) @(negedge clk);
            if (i < 10) bits[i] = ps2_data_pin;
            dev_clk_low = 0;
            if (i == 9 && ack) dev_data_low = 1;
            if (i == 10) dev_data_low = 0;
            if (hold_valid && i == 4) begin
                tx_valid   = 0;
                hold_valid = 0;
            end
            repeat (HALF) @(negedge clk);
        end
    endtask

    task automatic run_tx(input string nm, input logic [7:0] b,
                          input int nack, input bit hold);
        bit          exp_ok;
        int          exp_frames;
        int          frames;
        bit          seen;
        logic [9:0]  bits;
        exp_ok     = (nack < ALLOWED);
        exp_frames = exp_ok ? nack + 1 : ALLOWED;
        frames     = 0;
        done_cnt   = 0;
        err_cnt    = 0;
        @(negedge clk);
        check({nm, "_ready_in"}, tx_ready, 1);
        tx_data  = b;
        tx_valid = 1;
        @(negedge clk);
        if (hold) begin
            tx_data    = b ^ 8'h5A;
            hold_valid = 1;
        end else begin
            tx_valid = 0;
        end
        check({nm, "_busy"}, busy, 1);
        for (int f = 0; f <= ALLOWED; f++) begin
            wait_start(seen);
            if (!seen) break;
            dev_frame(f >= nack, bits);
            frames++;
            check({nm, "_byte"}, bits[7:0], b);
            check({nm, "_parity"}, bits[8], odd_par(b));
            check({nm, "_stop"}, bits[9], 1);
            check({nm, "_inhibit_w"}, last_inh_w, INH);
            if (f >= nack) break;
        end
        for (int i = 0; i < 2000 && !tx_ready; i++) @(negedge clk);
        check({nm, "_ready_back"}, tx_ready, 1);
        @(negedge clk);
        check({nm, "_frames"}, frames, exp_frames);
        check({nm, "_done"}, done_cnt, exp_ok ? 1 : 0);
        check({nm, "_err"}, err_cnt, exp_ok ? 0 : 1);
        check({nm, "_clk_rel"}, ps2_clk_oe, 0);
        check({nm, "_data_rel"}, ps2_data_oe, 0);
    endtask

    typedef struct {
        string      nm;
        logic [7:0] b;
        int         nack;
    } vec_t;

    vec_t vecs[$];

    initial begin
        bit  seen;
        bit  got;
        int  rel;
        int  errat;
        int  inhs;
        bit  prev;

        reset_n      = 0;
        tx_valid     = 0;
        tx_data      = 8'h00;
        dev_clk_low  = 0;
        dev_data_low = 0;
        repeat (3) @(negedge clk);
        check("rst_ready", tx_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", tx_done, 0);
        check("rst_err", tx_err, 0);
        check("rst_clk_oe", ps2_clk_oe, 0);
        check("rst_data_oe", ps2_data_oe, 0);
        reset_n = 1;
        repeat (3) @(negedge clk);

        vecs.push_back('{"set_leds", 8'hED, 0});
        vecs.push_back('{"zero", 8'h00, 0});
        vecs.push_back('{"one", 8'h01, 0});
        vecs.push_back('{"ack_byte", 8'hFA, 0});
        vecs.push_back('{"nack_once", 8'h3C, 1});
        vecs.push_back('{"nack_all", 8'h81, ALLOWED});
        foreach (vecs[i]) run_tx(vecs[i].nm, vecs[i].b, vecs[i].nack, 0);

        // Device never clocks: each frame must time out.
        @(negedge clk);
        tx_data  = 8'h55;
        tx_valid = 1;
        @(negedge clk);
        tx_valid = 0;
        got = 0; rel = 0; errat = 0; inhs = 0; prev = 0;
        for (int i = 0; i < ALLOWED * (INH + TO + 20) + 100; i++) begin
            @(negedge clk);
            if (!prev && ps2_clk_oe) inhs++;
            if (prev && !ps2_clk_oe) rel = i;
            prev = ps2_clk_oe;
            if (tx_err) begin
                got = 1;
                errat = i;
                break;
            end
        end
        check("to_err_seen", got, 1);
        check("to_latency", errat - rel, TO);
        check("to_frames", inhs, ALLOWED);
        check("to_clk_rel", ps2_clk_oe, 0);
        check("to_data_rel", ps2_data_oe, 0);
        @(negedge clk);
        check("to_ready_next", tx_ready, 1);

        // Reset in the middle of the data bits.
        tx_data  = 8'hA5;
        tx_valid = 1;
        @(negedge clk);
        tx_valid = 0;
        wait_start(seen);
        check("rst_mid_start", seen, 1);
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            dev_clk_low = 1;
            repeat (HALF) @(negedge clk);
            dev_clk_low = 0;
            repeat (HALF) @(negedge clk);
        end
        check("rst_mid_busy", busy, 1);
        #1 reset_n = 0;
        #1;
        check("rst_mid_clk_oe", ps2_clk_oe, 0);
        check("rst_mid_data_oe", ps2_data_oe, 0);
        check("rst_mid_ready", tx_ready, 1);
        repeat (2) @(negedge clk);
        reset_n = 1;
        repeat (2) @(negedge clk);
        run_tx("after_rst_ff", 8'hFF, 0, 0);

        // tx_valid held high with another byte while busy.
        run_tx("held_valid", 8'h12, 0, 1);
        repeat (50) @(negedge clk);
        check("held_no_second", busy, 0);

        for (int k = 0; k < 16; k++) begin
            logic [7:0] rb;
            int         rn;
            rb = 8'($urandom);
            rn = $urandom_range(0, ALLOWED);
            run_tx("rand", rb, rn, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
